// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointers, empty/count
// flags and a first-word-fall-through output register, all in rclk.
module fifo_rd_ctrl #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    localparam logic [31:0] THR = AEMPTY_THRESH;

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] cnt_next;
    logic              pop;
    logic              aempty_next;

    always_comb begin
        pop       = !rempty && (!dout_valid || dout_ready);
        rbinnext  = rbin + {{ADDRSIZE{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        wbin_s    = '0;
        // Gray-to-binary: each bit is the XOR of itself and all higher bits
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
        cnt_next    = wbin_s - rbinnext;
        aempty_next = (32'(cnt_next) <= THR);
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rcount  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            rcount  <= cnt_next;
            raempty <= aempty_next;
        end
    end

    // Pop reloads the register; a consume without pop just drops valid
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout       <= mem_rdata;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a behavioural write side fills a
// memory model; a monitor checks every accepted dout against the queue.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [4:0] rq2_wptr;
    logic [7:0] mem_rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rcount;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    logic [7:0] mem [16];
    logic [4:0] wbin;
    logic [7:0] q [$];

    int checks = 0;
    int failures = 0;

    logic [4:0] prev_rptr = '0;
    logic [3:0] prev_raddr = '0;
    logic       seen_pwrap = 1'b0;
    logic       seen_awrap = 1'b0;

    fifo_rd_ctrl #(
        .DATASIZE(8),
        .ADDRSIZE(4),
        .AEMPTY_THRESH(2)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .rq2_wptr(rq2_wptr),
        .mem_rdata(mem_rdata),
        .raddr(raddr),
        .rptr(rptr),
        .rempty(rempty),
        .raempty(raempty),
        .rcount(rcount),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    always #5 rclk = ~rclk;

    assign mem_rdata = mem[raddr];

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        wbin = wbin + 5'd1;
        rq2_wptr = gray(wbin);
        q.push_back(d);
    endtask

    // Scoreboard monitor: handshake seen at negedge completes on next posedge
    always @(negedge rclk) begin
        if (rrst_n === 1'b1 && dout_valid && dout_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %0h expected none", dout);
            end else begin
                chk("sb_data", 32'(dout), 32'(q.pop_front()));
            end
        end
        if (rrst_n === 1'b1) begin
            if (prev_rptr == 5'b10000 && rptr == 5'b00000)
                seen_pwrap = 1'b1;
            if (prev_raddr == 4'd15 && raddr == 4'd0)
                seen_awrap = 1'b1;
        end
        prev_rptr  = rptr;
        prev_raddr = raddr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rrst_n     = 1'b0;
        rq2_wptr   = '0;
        dout_ready = 1'b0;
        wbin       = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset then idle
        repeat (3) tick();
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_raempty", 32'(raempty), 1);
        chk("rst_dout", 32'(dout), 0);
        rrst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge rclk);
            chk("idle_rempty", 32'(rempty), 1);
            chk("idle_raempty", 32'(raempty), 1);
            chk("idle_rcount", 32'(rcount), 0);
            chk("idle_valid", 32'(dout_valid), 0);
            chk("idle_rptr", 32'(rptr), 0);
        end

        // Single word latency
        tick();
        write_word(8'hA5);
        tick();
        @(negedge rclk);
        chk("lat_rempty_n1", 32'(rempty), 0);
        chk("lat_valid_n1", 32'(dout_valid), 0);
        chk("lat_rcount_n1", 32'(rcount), 1);
        tick();
        @(negedge rclk);
        chk("lat_dout", 32'(dout), 32'h A5);
        chk("lat_valid", 32'(dout_valid), 1);
        chk("lat_raddr", 32'(raddr), 1);
        chk("lat_rptr", 32'(rptr), 32'b00001);
        chk("lat_rempty_n2", 32'(rempty), 1);
        chk("lat_rcount_n2", 32'(rcount), 0);
        tick();
        dout_ready = 1'b1;
        tick();
        @(negedge rclk);
        chk("lat_consumed", 32'(dout_valid), 0);
        tick();
        dout_ready = 1'b0;

        // Backpressure
        write_word(8'h11);
        tick();
        write_word(8'h22);
        tick();
        write_word(8'h33);
        tick();
        write_word(8'h44);
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            chk("bp_hold_dout", 32'(dout), 32'h11);
            chk("bp_hold_valid", 32'(dout_valid), 1);
            chk("bp_rcount", 32'(rcount), 3);
            tick();
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            chk("bp_stream_valid", 32'(dout_valid), 1);
            tick();
        end
        @(negedge rclk);
        chk("bp_drop_valid", 32'(dout_valid), 0);
        chk("bp_rempty", 32'(rempty), 1);
        chk("bp_rcount_end", 32'(rcount), 0);
        chk("bp_queue", 32'(q.size()), 0);

        // Streaming full FIFO: write pointer at 16 while held in reset
        tick();
        rrst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'h80 + 8'(i);
            q.push_back(8'h80 + 8'(i));
        end
        wbin       = 5'd16;
        rq2_wptr   = gray(wbin);
        dout_ready = 1'b1;
        tick();
        rrst_n = 1'b1;
        tick();
        @(negedge rclk);
        chk("full_rcount", 32'(rcount), 16);
        chk("full_rempty", 32'(rempty), 0);
        chk("full_raempty", 32'(raempty), 0);
        chk("full_valid0", 32'(dout_valid), 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            @(negedge rclk);
            chk("full_rcount_k", 32'(rcount), 32'(16 - k));
            chk("full_valid_k", 32'(dout_valid), 1);
            chk("full_raempty_k", 32'(raempty), ((16 - k) <= 2) ? 1 : 0);
            chk("full_rempty_k", 32'(rempty), (k == 16) ? 1 : 0);
        end
        tick();
        @(negedge rclk);
        chk("full_done_valid", 32'(dout_valid), 0);
        chk("full_rptr", 32'(rptr), 32'b11000);
        chk("full_raddr", 32'(raddr), 0);
        chk("full_queue", 32'(q.size()), 0);

        // Wrap-around: 40 words in bursts of 7 starting at pointer 16
        tick();
        dout_ready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            int n;
            n = (b < 5) ? 7 : 5;
            for (int j = 0; j < n; j++) begin
                tick();
                write_word(8'h40 + 8'(b * 7 + j));
            end
            repeat (3) tick();
            @(negedge rclk);
            chk("wrap_rcount", 32'(rcount), 32'(n - 1));
            chk("wrap_valid", 32'(dout_valid), 1);
            chk("wrap_dout", 32'(dout), 32'(8'h40 + 8'(b * 7)));
            tick();
            dout_ready = 1'b1;
            repeat (n + 2) tick();
            @(negedge rclk);
            chk("wrap_drained", 32'(dout_valid), 0);
            chk("wrap_rempty", 32'(rempty), 1);
            chk("wrap_rcount0", 32'(rcount), 0);
            tick();
            dout_ready = 1'b0;
        end
        chk("wrap_rptr_seen", 32'(seen_pwrap), 1);
        chk("wrap_raddr_seen", 32'(seen_awrap), 1);
        chk("wrap_rptr_end", 32'(rptr), 32'b10100);
        chk("wrap_raddr_end", 32'(raddr), 8);
        chk("wrap_queue", 32'(q.size()), 0);

        // Mid-operation reset
        for (int j = 0; j < 6; j++) begin
            tick();
            write_word(8'hC0 + 8'(j));
        end
        repeat (3) tick();
        @(negedge rclk);
        chk("mrst_pre_rcount", 32'(rcount), 5);
        chk("mrst_pre_valid", 32'(dout_valid), 1);
        tick();
        #1;
        rrst_n = 1'b0;
        #1;
        chk("mrst_rempty", 32'(rempty), 1);
        chk("mrst_raempty", 32'(raempty), 1);
        chk("mrst_rcount", 32'(rcount), 0);
        chk("mrst_valid", 32'(dout_valid), 0);
        chk("mrst_dout", 32'(dout), 0);
        chk("mrst_rptr", 32'(rptr), 0);
        chk("mrst_raddr", 32'(raddr), 0);
        q.delete();
        wbin     = '0;
        rq2_wptr = '0;
        tick();
        rrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge rclk);
            chk("post_rempty", 32'(rempty), 1);
            chk("post_valid", 32'(dout_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
